wb_coalescer: RTL and testbench
===============================

WB_COALESCER -- requirements
Module: wb_coalescer

Interface
REQ-001 Parameter NUM_TIDS, 1024, thread-ID space size and wb_tid_bitmap width.
REQ-002 Parameter MAX_BATCH, 256, distinct TIDs per collection that force an emit.
REQ-003 Parameter TIMEOUT, 16, consecutive no-accept cycles in COLLECT that force an emit.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 ld_ret_valid  input  1  load return present.
REQ-007 ld_ret_tid  input  10  TID of the returning load.
REQ-008 ld_ret_reg  input  8  destination register of the returning load.
REQ-009 ld_ret_ready  output  1  return accepted when ld_ret_valid && ld_ret_ready at a rising edge.
REQ-010 flush  input  1  level request to emit the open collection (CTA end).
REQ-011 wb_valid  output  1  one-cycle writeback pulse to the dispatcher scoreboard.
REQ-012 wb_tid_bitmap  output  NUM_TIDS  TIDs whose ld_dest_reg is now written; bit i = TID i.
REQ-013 ld_dest_reg  output  8  register released by this writeback.
REQ-014 coalescer_busy  output  1  high when state != IDLE.

Function
REQ-015 States: IDLE (no collection), COLLECT (open collection: cur_reg, bitmap, cnt, idle_cnt), EMIT (pulse cycle).
REQ-016 ld_ret_ready SHALL equal (state != EMIT) && !flush.
REQ-017 IDLE, accept -> COLLECT; cur_reg = ld_ret_reg, bitmap = one-hot(ld_ret_tid), cnt = 1, idle_cnt = 0.
REQ-018 COLLECT, accept with ld_ret_reg == cur_reg: set bitmap[ld_ret_tid]; cnt += 1 only if bit was clear; idle_cnt = 0.
REQ-019 Duplicate TID in one collection: bitmap and cnt unchanged, idle_cnt cleared.
REQ-020 COLLECT, accept with ld_ret_reg != cur_reg: store return in pending slot (reg, tid); next state EMIT.
REQ-021 COLLECT, accept making cnt == MAX_BATCH: next state EMIT, accepted TID included.
REQ-022 COLLECT, no accept: idle_cnt += 1; if idle_cnt == TIMEOUT-1 before increment, next state EMIT (last accept at cycle N -> wb_valid in cycle N+TIMEOUT+1).
REQ-023 COLLECT with flush high: next state EMIT (no accept that cycle).
REQ-024 EMIT: wb_valid = 1, wb_tid_bitmap = bitmap, ld_dest_reg = cur_reg for exactly that cycle; then pending slot valid -> COLLECT loaded from pending (cnt = 1), else IDLE; pending cleared.
REQ-025 Outside EMIT: wb_valid = 0, wb_tid_bitmap = 0, ld_dest_reg = 0.
REQ-026 Emit latency: trigger detected at edge N -> wb_valid high in cycle N+1; no combinational path from inputs to wb_* outputs.
REQ-027 flush in IDLE, or EMIT: no pulse generated; no effect beyond ld_ret_ready = 0.
REQ-028 Back-to-back EMIT never occurs; every emitted bitmap is non-zero.
REQ-029 cnt width SHALL hold MAX_BATCH; idle_cnt width SHALL hold TIMEOUT-1; no wrap.

Reset
REQ-030 rst high at an edge: state = IDLE, bitmap/cnt/idle_cnt/pending cleared; all outputs 0 except ld_ret_ready = 1 the following cycle.
REQ-031 rst mid-collection or during EMIT SHALL discard the collection with no wb_valid pulse in or after the reset cycle.

Verification
REQ-032 TIDs 0,1,2,3 reg 5 on cycles 0-3, then idle -> one pulse in cycle 20, bitmap 0xF, ld_dest_reg 5; ready high throughout.
REQ-033 TIDs 0-3 reg 0 cycles 0-3, TID 4 reg 1 cycle 4 -> pulse cycle 5 (bitmap 0xF, reg 0), ld_ret_ready 0 in cycle 5; later pulse bitmap 0x10, reg 1.
REQ-034 TID 7 reg 3 twice, TID 9 reg 3, flush cycle 3 -> pulse cycle 4 bitmap 0x280, reg 3; ld_ret_ready 0 while flush high.
REQ-035 TIDs 0-255 reg 2 consecutive -> pulse the cycle after TID 255 with bitmap[255:0] all ones, [1023:256] zero.
REQ-036 flush pulsed in IDLE -> no wb_valid; rst in cycle 2 of a 4-TID collection -> no wb_valid ever, outputs 0, coalescer_busy 0.

Source files
------------

// File: rtl/wb_coalescer.sv
// -----------------------------------------------------------------------------
// wb_coalescer
//
// Gathers load returns that target the same destination register into one
// per-register writeback. The writeback carries a bitmap of every thread ID
// whose copy of that register is now valid. A collection is closed and emitted
// when any of these happens:
//   - a return arrives for a different register. That return is parked and
//     opens the next collection.
//   - MAX_BATCH distinct TIDs have been gathered.
//   - TIMEOUT consecutive cycles pass without an accepted return.
//   - flush is raised.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   ld_ret_valid    load return present
//   ld_ret_tid      thread ID of the returning load
//   ld_ret_reg      destination register of the returning load
//   ld_ret_ready    return accepted on valid && ready at a rising edge
//   flush           level request to close the open collection
//   wb_valid        one-cycle writeback pulse
//   wb_tid_bitmap   TIDs released by this writeback (bit i = TID i)
//   ld_dest_reg     register released by this writeback
//   coalescer_busy  high whenever a collection is open or being emitted
// -----------------------------------------------------------------------------
module wb_coalescer #(
  parameter int NUM_TIDS  = 1024,
  parameter int MAX_BATCH = 256,
  parameter int TIMEOUT   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ld_ret_valid,
  input  logic [$clog2(NUM_TIDS)-1:0] ld_ret_tid,
  input  logic [7:0]                  ld_ret_reg,
  output logic                        ld_ret_ready,
  input  logic                        flush,
  output logic                        wb_valid,
  output logic [NUM_TIDS-1:0]         wb_tid_bitmap,
  output logic [7:0]                  ld_dest_reg,
  output logic                        coalescer_busy
);

  localparam int TID_W  = $clog2(NUM_TIDS);
  localparam int CNT_W  = $clog2(MAX_BATCH + 1);
  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_BATCH);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_EMIT    = 2'd2
  } state_t;

  state_t               state_q,      state_d;
  logic [7:0]           cur_reg_q,    cur_reg_d;
  logic [NUM_TIDS-1:0]  bitmap_q,     bitmap_d;
  logic [CNT_W-1:0]     cnt_q,        cnt_d;
  logic [IDLE_W-1:0]    idle_cnt_q,   idle_cnt_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [7:0]           pend_reg_q,   pend_reg_d;
  logic [TID_W-1:0]     pend_tid_q,   pend_tid_d;
  logic                 wb_valid_q,   wb_valid_d;

  logic accept;

  // Ready depends only on registered state and the flush level. Blocking
  // returns during EMIT means the pending slot never needs more than one entry.
  assign ld_ret_ready = (state_q != S_EMIT) && !flush;
  assign accept       = ld_ret_valid && ld_ret_ready;

  always_comb begin
    state_d      = state_q;
    cur_reg_d    = cur_reg_q;
    bitmap_d     = bitmap_q;
    cnt_d        = cnt_q;
    idle_cnt_d   = idle_cnt_q;
    pend_valid_d = pend_valid_q;
    pend_reg_d   = pend_reg_q;
    pend_tid_d   = pend_tid_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d              = S_COLLECT;
          cur_reg_d            = ld_ret_reg;
          bitmap_d             = '0;
          bitmap_d[ld_ret_tid] = 1'b1;
          cnt_d                = CNT_W'(1);
          idle_cnt_d           = '0;
        end
      end

      S_COLLECT: begin
        if (flush) begin
          state_d = S_EMIT;
        end else if (accept) begin
          if (ld_ret_reg != cur_reg_q) begin
            // A different register closes this collection. Park the
            // return so that it seeds the next collection.
            pend_valid_d = 1'b1;
            pend_reg_d   = ld_ret_reg;
            pend_tid_d   = ld_ret_tid;
            state_d      = S_EMIT;
          end else begin
            idle_cnt_d = '0;
            // A duplicate TID only refreshes the idle timer.
            if (!bitmap_q[ld_ret_tid]) begin
              bitmap_d[ld_ret_tid] = 1'b1;
              cnt_d                = cnt_q + CNT_W'(1);
              if (cnt_q + CNT_W'(1) == CNT_MAX) begin
                state_d = S_EMIT;
              end
            end
          end
        end else if (idle_cnt_q == IDLE_MAX) begin
          state_d = S_EMIT;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end

      S_EMIT: begin
        // bitmap_q and cur_reg_q are presented on the outputs during this
        // cycle, so they are only replaced at the end of it.
        idle_cnt_d   = '0;
        pend_valid_d = 1'b0;
        if (pend_valid_q) begin
          state_d              = S_COLLECT;
          cur_reg_d            = pend_reg_q;
          bitmap_d             = '0;
          bitmap_d[pend_tid_q] = 1'b1;
          cnt_d                = CNT_W'(1);
        end else begin
          state_d   = S_IDLE;
          cur_reg_d = '0;
          bitmap_d  = '0;
          cnt_d     = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    wb_valid_d = (state_d == S_EMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_reg_q    <= '0;
      bitmap_q     <= '0;
      cnt_q        <= '0;
      idle_cnt_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_reg_q   <= '0;
      pend_tid_q   <= '0;
      wb_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_reg_q    <= cur_reg_d;
      bitmap_q     <= bitmap_d;
      cnt_q        <= cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_reg_q   <= pend_reg_d;
      pend_tid_q   <= pend_tid_d;
      wb_valid_q   <= wb_valid_d;
    end
  end

  // The writeback fields are gated by the registered pulse, so they read zero
  // outside the emit cycle and have no path from any input.
  assign wb_valid       = wb_valid_q;
  assign wb_tid_bitmap  = wb_valid_q ? bitmap_q : '0;
  assign ld_dest_reg    = wb_valid_q ? cur_reg_q : '0;
  assign coalescer_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_wb_coalescer.sv
// -----------------------------------------------------------------------------
// tb_wb_coalescer
//
// Directed scenarios followed by a randomized phase. Every cycle is compared
// against an event-scheduled reference model. The model tracks the open
// collection as a TID set, the cycle of the last accepted return, and the
// cycle in which the next writeback is due.
// -----------------------------------------------------------------------------
module tb_wb_coalescer;

  localparam int NT   = 1024;
  localparam int MAXB = 256;
  localparam int TOUT = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            ld_ret_valid;
  logic [9:0]      ld_ret_tid;
  logic [7:0]      ld_ret_reg;
  logic            ld_ret_ready;
  logic            flush;
  logic            wb_valid;
  logic [NT-1:0]   wb_tid_bitmap;
  logic [7:0]      ld_dest_reg;
  logic            coalescer_busy;

  wb_coalescer #(.NUM_TIDS(NT), .MAX_BATCH(MAXB), .TIMEOUT(TOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .ld_ret_valid   (ld_ret_valid),
    .ld_ret_tid     (ld_ret_tid),
    .ld_ret_reg     (ld_ret_reg),
    .ld_ret_ready   (ld_ret_ready),
    .flush          (flush),
    .wb_valid       (wb_valid),
    .wb_tid_bitmap  (wb_tid_bitmap),
    .ld_dest_reg    (ld_dest_reg),
    .coalescer_busy (coalescer_busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state
  logic          m_open;
  logic [7:0]    m_reg;
  logic [NT-1:0] m_bits;
  int            m_cnt;
  int            m_last;
  int            emit_at;
  logic          p_v;
  int            p_reg;
  int            p_tid;

  typedef struct {
    int            t;
    logic [NT-1:0] bm;
    logic [7:0]    rg;
  } pulse_t;
  pulse_t pulses[$];

  task automatic chk(input string tag, input logic [NT-1:0] obs, input logic [NT-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_open  = 1'b0;
    m_reg   = '0;
    m_bits  = '0;
    m_cnt   = 0;
    m_last  = 0;
    emit_at = -1;
    p_v     = 1'b0;
    p_reg   = 0;
    p_tid   = 0;
  endtask

  task automatic open_coll(input int rg, input int tid);
    m_open      = 1'b1;
    m_reg       = rg[7:0];
    m_bits      = '0;
    m_bits[tid] = 1'b1;
    m_cnt       = 1;
    m_last      = cyc;
  endtask

  // One clock cycle: drive the inputs, compare the outputs, then advance the model.
  task automatic step(input logic v, input int tid, input int rg, input logic fl, input logic rs);
    logic exp_v, exp_rdy, acc;
    @(posedge clk);
    #1;
    ld_ret_valid = v;
    ld_ret_tid   = tid[9:0];
    ld_ret_reg   = rg[7:0];
    flush        = fl;
    rst          = rs;
    #1;
    exp_v   = (emit_at == cyc);
    exp_rdy = !exp_v && !fl;
    chk("wb_valid", NT'(wb_valid), NT'(exp_v));
    chk("ld_ret_ready", NT'(ld_ret_ready), NT'(exp_rdy));
    chk("wb_tid_bitmap", wb_tid_bitmap, exp_v ? m_bits : '0);
    chk("ld_dest_reg", NT'(ld_dest_reg), exp_v ? NT'(m_reg) : '0);
    chk("coalescer_busy", NT'(coalescer_busy), NT'(m_open || exp_v));
    if (wb_valid === 1'b1) pulses.push_back('{cyc, wb_tid_bitmap, ld_dest_reg});
    acc = v && exp_rdy;

    if (rs) begin
      model_clear();
    end else if (exp_v) begin
      emit_at = -1;
      if (p_v) begin
        open_coll(p_reg, p_tid);
        p_v = 1'b0;
      end else begin
        m_open = 1'b0;
        m_bits = '0;
        m_cnt  = 0;
      end
    end else if (m_open) begin
      if (fl) begin
        emit_at = cyc + 1;
      end else if (acc) begin
        if (rg[7:0] != m_reg) begin
          p_v = 1'b1; p_reg = rg; p_tid = tid;
          emit_at = cyc + 1;
        end else begin
          if (!m_bits[tid]) begin
            m_bits[tid] = 1'b1;
            m_cnt++;
          end
          m_last = cyc;
          if (m_cnt == MAXB) emit_at = cyc + 1;
        end
      end else if (cyc - m_last == TOUT) begin
        emit_at = cyc + 1;
      end
    end else if (acc) begin
      open_coll(rg, tid);
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    int base;
    int rg_cur;
    int burst;
    logic [NT-1:0] want;

    ld_ret_valid = 1'b0;
    ld_ret_tid   = '0;
    ld_ret_reg   = '0;
    flush        = 1'b0;
    rst          = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state is checked by the first idle cycles.
    idle(3);

    // Four TIDs on reg 5, then a timeout.
    pulses.delete();
    base = cyc;
    for (int i = 0; i < 4; i++) step(1'b1, i, 5, 1'b0, 1'b0);
    idle(25);
    chk("t32_npulse", NT'(pulses.size()), NT'(1));
    if (pulses.size() >= 1) begin
      chk("t32_cycle", NT'(pulses[0].t - base), NT'(20));
      chk("t32_bitmap", pulses[0].bm, NT'(32'hF));
      chk("t32_reg", NT'(pulses[0].rg), NT'(5));
    end

    // A register change closes the collection and seeds the next one.
    pulses.delete();
    base = cyc;
    for (int i = 0; i < 4; i++) step(1'b1, i, 0, 1'b0, 1'b0);
    step(1'b1, 4, 1, 1'b0, 1'b0);
    idle(25);
    chk("t33_npulse", NT'(pulses.size()), NT'(2));
    if (pulses.size() >= 2) begin
      chk("t33_cycle0", NT'(pulses[0].t - base), NT'(5));
      chk("t33_bitmap0", pulses[0].bm, NT'(32'hF));
      chk("t33_reg0", NT'(pulses[0].rg), NT'(0));
      chk("t33_bitmap1", pulses[1].bm, NT'(32'h10));
      chk("t33_reg1", NT'(pulses[1].rg), NT'(1));
    end

    // Duplicate TID followed by a flush.
    pulses.delete();
    base = cyc;
    step(1'b1, 7, 3, 1'b0, 1'b0);
    step(1'b1, 7, 3, 1'b0, 1'b0);
    step(1'b1, 9, 3, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b1, 1'b0);
    chk("t34_ready_flush", NT'(ld_ret_ready), NT'(0));
    idle(25);
    chk("t34_npulse", NT'(pulses.size()), NT'(1));
    if (pulses.size() >= 1) begin
      chk("t34_cycle", NT'(pulses[0].t - base), NT'(4));
      chk("t34_bitmap", pulses[0].bm, NT'(32'h280));
      chk("t34_reg", NT'(pulses[0].rg), NT'(3));
    end

    // A full batch of MAX_BATCH distinct TIDs.
    pulses.delete();
    base = cyc;
    for (int i = 0; i < MAXB; i++) step(1'b1, i, 2, 1'b0, 1'b0);
    idle(25);
    want = '0;
    for (int i = 0; i < MAXB; i++) want[i] = 1'b1;
    chk("t35_npulse", NT'(pulses.size()), NT'(1));
    if (pulses.size() >= 1) begin
      chk("t35_cycle", NT'(pulses[0].t - base), NT'(MAXB));
      chk("t35_bitmap", pulses[0].bm, want);
      chk("t35_reg", NT'(pulses[0].rg), NT'(2));
    end

    // Flush in IDLE, then a reset in the middle of a collection.
    pulses.delete();
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b1, 1'b0);
    step(1'b1, 0, 6, 1'b0, 1'b0);
    step(1'b1, 1, 6, 1'b0, 1'b0);
    step(1'b0, 2, 6, 1'b0, 1'b1);
    idle(30);
    chk("t36_npulse", NT'(pulses.size()), NT'(0));
    chk("t36_busy", NT'(coalescer_busy), NT'(0));
    chk("t36_bitmap", wb_tid_bitmap, '0);

    // Randomized traffic: alternating bursts and gaps, occasional register
    // changes, flushes and resets.
    rg_cur = 0;
    for (int b = 0; b < 120; b++) begin
      burst = $urandom_range(1, 40);
      for (int i = 0; i < burst; i++) begin
        logic v, fl, rs;
        int tid;
        v   = ($urandom_range(0, 99) < 70);
        tid = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 15) : $urandom_range(0, NT - 1);
        if ($urandom_range(0, 99) < 6) rg_cur = $urandom_range(0, 3);
        fl  = ($urandom_range(0, 99) < 3);
        rs  = ($urandom_range(0, 999) < 3) && (emit_at != cyc);
        step(v, tid, rg_cur, fl, rs);
      end
      idle($urandom_range(0, 22));
    end
    idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
